// File: rtl/seq_pattern_fsm.sv
// -----------------------------------------------------------------------------
// seq_pattern_fsm
//
// Moore-style serial pattern detector. The state is the length of the longest
// prefix of PATTERN (MSB received first) that is a suffix of the bits accepted
// so far. A complete match produces a one-cycle registered pulse on `match`
// and bumps a saturating match counter.
//
// Parameters:
//   LEN      pattern length in bits (2..32)
//   PATTERN  pattern bits, MSB first on the wire
//   OVERLAP  1 = overlapping matches allowed, 0 = restart from empty after match
//   CNT_W    match counter width
//   TIMEOUT  idle limit (only with SEQ_PATTERN_TIMEOUT_EN defined)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       sample qualifier; din is consumed only when en=1
//   din      serial data bit
//   clr      synchronous clear of count (wins over a simultaneous increment)
//   state_o  current matched-prefix length, 0..LEN
//   match    one-cycle registered pulse, high in the cycle after a full match
//   count    saturating number of matches
//
// Optional build macro: SEQ_PATTERN_TIMEOUT_EN
//   When defined, a partial (or parked full) match is abandoned after TIMEOUT
//   consecutive en=0 cycles; the state returns to 0 on the TIMEOUT-th idle
//   edge. The timeout never touches match or count.
//
// Handshake: there is no back-pressure. en is a plain qualifier; every edge
// with en=1 consumes exactly one din bit.
// -----------------------------------------------------------------------------
module seq_pattern_fsm #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
`ifdef SEQ_PATTERN_TIMEOUT_EN
  parameter int             TIMEOUT = 16,
`endif
  localparam int            SW      = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic [SW-1:0]    state_o,
  output logic             match,
  output logic [CNT_W-1:0] count
);

  // Only the two end points get names; intermediate prefix lengths are
  // reached through the elaborated transition tables.
  typedef enum logic [SW-1:0] {
    ST_EMPTY = '0,
    ST_FULL  = SW'(LEN)
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Next prefix length from state s on bit b. Checks every candidate length k
  // (ascending, so the longest match wins) against the tail of the sequence
  // "matched prefix of length s, then b". A non-overlapping detector sitting
  // at the full length behaves as if it were empty.
  function automatic int calc_next(input int s_in, input logic b);
    int   s;
    int   res;
    int   idx;
    int   pidx;
    logic ok;
    logic bit_at;
    s   = (s_in == LEN && !OVERLAP) ? 0 : s_in;
    res = 0;
    for (int k = 1; k <= LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          idx    = s + 1 - k + j;
          pidx   = (idx < LEN) ? (LEN - 1 - idx) : 0;
          bit_at = (idx == s) ? b : PATTERN[pidx];
          if (bit_at != PATTERN[LEN-1-j]) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Transition tables, constant after elaboration.
  logic [SW-1:0] nxt0 [LEN+1];
  logic [SW-1:0] nxt1 [LEN+1];

  for (genvar g = 0; g <= LEN; g++) begin : g_tab
    assign nxt0[g] = SW'(calc_next(g, 1'b0));
    assign nxt1[g] = SW'(calc_next(g, 1'b1));
  end

  state_t           state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef SEQ_PATTERN_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    count_d = count_q;
`ifdef SEQ_PATTERN_TIMEOUT_EN
    idle_d  = '0;
`endif
    if (en) begin
      state_d = state_t'(din ? nxt1[state_q] : nxt0[state_q]);
      // Any accepted bit that lands on the full length is a fresh match,
      // including LEN -> LEN on self-overlapping patterns.
      match_d = (state_d == ST_FULL);
    end
`ifdef SEQ_PATTERN_TIMEOUT_EN
    else if (state_q != ST_EMPTY) begin
      // idle_q counts earlier idle edges, so this edge is idle_q+1.
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d = ST_EMPTY;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif

    if (clr) begin
      count_d = '0;
    end else if (match_d && count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      match_q <= 1'b0;
      count_q <= '0;
`ifdef SEQ_PATTERN_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
`ifdef SEQ_PATTERN_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign state_o = state_q;
  assign match   = match_q;
  assign count   = count_q;

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_fsm
//
// Three detectors share one input stream: overlapping (8-bit count),
// non-overlapping (8-bit count) and overlapping with a 2-bit count. A
// reference model tracks the accepted bit history of each and derives the
// expected state as the longest pattern prefix equal to a history suffix.
// -----------------------------------------------------------------------------
module tb_seq_pattern_fsm;

  localparam int         LEN = 4;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         TO  = 4;
  localparam int         OVL_M [3] = '{1, 0, 1};
  localparam int         CMAX  [3] = '{255, 255, 3};
`ifdef SEQ_PATTERN_TIMEOUT_EN
  localparam bit         TO_EN = 1'b1;
`else
  localparam bit         TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, en, din, clr;
  always #5 clk = ~clk;

  logic [2:0] st0, st1, st2;
  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

`ifdef SEQ_PATTERN_TIMEOUT_EN
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8), .TIMEOUT(TO))
    dut_ovl (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st0), .match(m0), .count(c0));
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8), .TIMEOUT(TO))
    dut_novl (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st1), .match(m1), .count(c1));
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2), .TIMEOUT(TO))
    dut_c2 (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st2), .match(m2), .count(c2));
`else
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    dut_ovl (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st0), .match(m0), .count(c0));
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    dut_novl (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st1), .match(m1), .count(c1));
  seq_pattern_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut_c2 (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .state_o(st2), .match(m2), .count(c2));
`endif

  // ---------------- reference model ----------------
  logic [63:0] m_hist  [3];
  int          m_hlen  [3];
  int          m_st    [3];
  int          m_idle  [3];
  int          m_cnt   [3];
  logic        m_match [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Longest k such that the last k accepted bits spell the first k pattern bits.
  function automatic int longest(input logic [63:0] h, input int hl);
    logic [63:0] pat64;
    logic [63:0] mask;
    int best;
    pat64 = 64'(PAT);
    best  = 0;
    for (int k = 1; k <= LEN; k++) begin
      if (k <= hl) begin
        mask = (64'd1 << k) - 64'd1;
        if ((h & mask) == (pat64 >> (LEN - k))) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_hist[m] = '0; m_hlen[m] = 0; m_st[m] = 0;
      m_idle[m] = 0;  m_cnt[m]  = 0; m_match[m] = 1'b0;
    end
  endtask

  task automatic model_step(input logic e, input logic d, input logic c);
    for (int m = 0; m < 3; m++) begin
      m_match[m] = 1'b0;
      if (e) begin
        m_idle[m] = 0;
        m_hist[m] = {m_hist[m][62:0], d};
        if (m_hlen[m] < 64) m_hlen[m]++;
        m_st[m] = longest(m_hist[m], m_hlen[m]);
        if (m_st[m] == LEN) begin
          m_match[m] = 1'b1;
          if (OVL_M[m] == 0) m_hlen[m] = 0;
        end
      end else if (TO_EN && m_st[m] != 0) begin
        m_idle[m]++;
        if (m_idle[m] == TO) begin
          m_st[m] = 0; m_hlen[m] = 0; m_idle[m] = 0;
        end
      end else begin
        m_idle[m] = 0;
      end
      if (c) m_cnt[m] = 0;
      else if (m_match[m] && m_cnt[m] < CMAX[m]) m_cnt[m]++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ovl.state",  32'(st0), 32'(m_st[0]));
    chk("ovl.match",  32'(m0),  32'(m_match[0]));
    chk("ovl.count",  32'(c0),  32'(m_cnt[0]));
    chk("novl.state", 32'(st1), 32'(m_st[1]));
    chk("novl.match", 32'(m1),  32'(m_match[1]));
    chk("novl.count", 32'(c1),  32'(m_cnt[1]));
    chk("c2.state",   32'(st2), 32'(m_st[2]));
    chk("c2.match",   32'(m2),  32'(m_match[2]));
    chk("c2.count",   32'(c2),  32'(m_cnt[2]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic e, input logic d, input logic c);
    en = e; din = d; clr = c;
    @(posedge clk);
    model_step(e, d, c);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Reset raised between edges; outputs must clear without a clock edge.
  task automatic async_rst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Basic match 1,0,1,1
    send_bits(16'b1011, 4);
    idle(1);
    chk("t1.count_const", 32'(c0), 32'd1);

    // Overlap vs non-overlap: 1,0,1,1,0,1,1
    async_rst();
    send_bits(16'b1011011, 7);
    chk("t2.ovl_count_const", 32'(c0), 32'd2);
    chk("t2.novl_count_const", 32'(c1), 32'd1);

    // Fallback: 1,0,1,0,1,1
    async_rst();
    send_bits(16'b1010, 4);
    chk("t3.fallback_const", 32'(st0), 32'd2);
    send_bits(16'b11, 2);

    // Gaps with en=0, and parking at full length
    async_rst();
    cycle(1'b1, 1'b1, 1'b0); idle(1);
    cycle(1'b1, 1'b0, 1'b0); idle(1);
    cycle(1'b1, 1'b1, 1'b0); idle(1);
    cycle(1'b1, 1'b1, 1'b0); idle(2);

    // Saturation of the 2-bit counter, then clr on the 6th match
    async_rst();
    send_bits(16'b1011, 4);
    for (int i = 0; i < 4; i++) send_bits(16'b011, 3);
    chk("t5.sat_const", 32'(c2), 32'd3);
    send_bits(16'b01, 2);
    cycle(1'b1, 1'b1, 1'b1);
    chk("t5.clr_match_const", 32'(m0), 32'd1);
    send_bits(16'b101, 3);
    async_rst();

    // Idle timeout (state holds when the feature is absent)
    send_bits(16'b10, 2);
    idle(4);
    async_rst();
    send_bits(16'b10, 2);
    idle(3);
    send_bits(16'b11, 2);

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_rst();
      end else if ($urandom_range(0, 29) == 0) begin
        idle($urandom_range(1, 6));
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 19) == 0));
      end
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
